// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, mid-bit sampling from a baud counter,
// one-cycle valid / frame_error pulses. States: IDLE wait start | START validate | DATA shift | STOP check | BRK wait line high.
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic                  sync1_q;
  logic                  rx_s;
  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH:0]   shift_ext;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  fe_q, fe_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= line;
      rx_s    <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    shift_ext = {rx_s, shift_q};
    data_d    = data_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    fe_d      = 1'b0;

    // A good stop bit publishes the word on the following edge.
    if (done_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = shift_ext[DATA_WIDTH:1];
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = fe_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the same serial link the team's transmitter drives: 8N1 framing, LSB first, line idles high. It synchronises the asynchronous RX line, detects and validates the start bit, samples each bit at its centre using an internal baud counter, and presents the received word with a one-cycle valid pulse. It sits between the board RX pin and the consuming logic, for example a loopback to the transmitter or a display.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUDRATE, 9600, line bit rate in baud.
DATA_WIDTH, 8, data bits per frame (1..15).
Derived constants (localparams, not overridable):
- CLKS_PER_BIT = CLK_FREQ / BAUDRATE, using integer division; must be at least 4.
- HALF_BIT = CLKS_PER_BIT / 2.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset_n  input  1  asynchronous, active-low reset.
line  input  1  RX serial line; asynchronous to clk; idles high.
data  output  DATA_WIDTH  last correctly framed word; holds its value until the next good frame.
valid  output  1  one-cycle pulse when data has just been updated.
frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
busy  output  1  high while the state machine is not in IDLE.

Behaviour:
- Reset (reset_n=0, takes effect immediately):
  - data=0, valid=0, frame_error=0, busy=0.
  - state=IDLE; both synchroniser flops =1; counters =0.
  - Reset asserted mid-frame abandons the frame with no output pulse.
- Synchroniser: 2-flop chain; rx_s is the second flop. All decisions use rx_s only.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state change; otherwise increments each clk.
- Bit index: width $clog2(DATA_WIDTH+1).
- IDLE:
  - When rx_s==0: go to START, clear counter.
- START:
  - At counter==HALF_BIT-1, sample rx_s.
  - rx_s==0: go to DATA, bit index=0.
  - rx_s==1: treat as a glitch; return to IDLE with no pulse.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample rx_s into the shift register.
  - Shift register shifts right and inserts at the MSB, so the first bit received lands in data[0].
  - Bit index increments; after DATA_WIDTH samples, go to STOP.
- STOP:
  - At counter==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: on the next edge, data<=shift register, valid=1 for exactly one cycle; go to IDLE.
  - rx_s==0: frame_error=1 for one cycle; data unchanged; go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge, arriving half a bit later, be detected with no lost frame.
- Latency: valid rises exactly 2 + HALF_BIT + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 clk edges after the first edge at which line is sampled low (start-bit leading edge).
- valid and frame_error are never high in the same cycle.
- busy = (state != IDLE); it is combinational from the state register.

Test Plan:
(All scenarios use CLK_FREQ=160, BAUDRATE=10, so CLKS_PER_BIT=16 and HALF_BIT=8; the bench drives line at 16 clk per bit.)
- Reset hold: reset_n=0 for 5 clk with line toggling -> data=0, valid=0, frame_error=0, busy=0 throughout.
- Single frame 0xA5 -> one valid pulse, data=8'hA5, frame_error never high, valid exactly 2+8+9*16+1=155 edges after the start edge.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three valid pulses, data=00, FF, 3C in order.
- Glitch: line low for 4 clk, then high -> busy rises then returns low before the half-bit sample, no valid pulse, data unchanged.
- Framing error: frame 0x5A with stop bit low, line held low for 40 clk, then high -> frame_error pulses once, no valid pulse, data keeps its old value, busy stays high until line returns high. A following good frame 0x81 then gives data=81.
- Reset mid-frame: reset_n pulsed low during bit 3 of frame 0x77 -> no pulse for that frame; the next full frame 0x12 gives data=12.
